// File: rtl/regfile_access_arbiter_pkg.sv
// Shared types and defaults for the register-file access arbiter.
package regfile_arb_pkg;
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    RDATA = 2'd2
  } state_e;

  localparam logic REQ_PARSER = 1'b0;
  localparam logic REQ_LOCAL  = 1'b1;

  localparam int DEF_DATA_W = 8;
  localparam int DEF_ADDR_W = 8;
  localparam int DEF_DEPTH  = 16;
endpackage

// File: rtl/regfile_access_arbiter_if.sv
// Requester and register-file side signals of the arbiter; slave = arbiter.
interface regfile_arb_if
  import regfile_arb_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W
);
  logic              p_req,    l_req;
  logic              p_we,     l_we;
  logic [ADDR_W-1:0] p_addr,   l_addr;
  logic [DATA_W-1:0] p_wdata,  l_wdata;
  logic              p_gnt,    l_gnt;
  logic              p_rvalid, l_rvalid;
  logic              p_err,    l_err;
  logic [DATA_W-1:0] rd_data;
  logic              rf_en;
  logic              rf_we;
  logic [ADDR_W-1:0] rf_addr;
  logic [DATA_W-1:0] rf_wdata;
  logic [DATA_W-1:0] rf_rdata;
  logic              busy;

  modport slave (
    input  p_req, l_req, p_we, l_we, p_addr, l_addr, p_wdata, l_wdata, rf_rdata,
    output p_gnt, l_gnt, p_rvalid, l_rvalid, p_err, l_err, rd_data,
           rf_en, rf_we, rf_addr, rf_wdata, busy
  );

  modport master (
    output p_req, l_req, p_we, l_we, p_addr, l_addr, p_wdata, l_wdata, rf_rdata,
    input  p_gnt, l_gnt, p_rvalid, l_rvalid, p_err, l_err, rd_data,
           rf_en, rf_we, rf_addr, rf_wdata, busy
  );
endinterface

// File: rtl/regfile_access_arbiter_rr_pick2.sv
// Combinational 2-way round-robin select; index 0 = parser, 1 = local.
module rr_pick2 (
  input  logic [1:0] i_req,
  input  logic       i_last,
  output logic       o_vld,
  output logic       o_win
);
  assign o_vld = |i_req;
  // On a tie the requester that did not win last time goes first.
  assign o_win = (&i_req) ? ~i_last : i_req[1];
endmodule

// File: rtl/regfile_access_arbiter.sv
// Round-robin arbiter sharing one single-port register file between the
// UART parser and a local requester; flags out-of-range addresses.
module regfile_access_arbiter
  import regfile_arb_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DEPTH  = DEF_DEPTH
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  regfile_arb_if.slave  bus
);
  state_e            r_state, w_state_nxt;
  logic              r_last, r_owner, r_we, r_inr;
  logic              r_p_gnt, r_l_gnt, r_p_err, r_l_err, r_p_rvalid, r_l_rvalid;
  logic              r_rf_en, r_rf_we, r_rd_sel;
  logic [ADDR_W-1:0] r_rf_addr;
  logic [DATA_W-1:0] r_rf_wdata;

  logic              w_pick_vld, w_pick_win, w_sel_we, w_sel_inr;
  logic [ADDR_W-1:0] w_sel_addr;
  logic [DATA_W-1:0] w_sel_wdata;

  rr_pick2 u_pick (
    .i_req  ({bus.l_req, bus.p_req}),
    .i_last (r_last),
    .o_vld  (w_pick_vld),
    .o_win  (w_pick_win)
  );

  always_comb begin
    w_sel_we    = (w_pick_win == REQ_LOCAL) ? bus.l_we    : bus.p_we;
    w_sel_addr  = (w_pick_win == REQ_LOCAL) ? bus.l_addr  : bus.p_addr;
    w_sel_wdata = (w_pick_win == REQ_LOCAL) ? bus.l_wdata : bus.p_wdata;
    // One extra bit so DEPTH == 2**ADDR_W still compares correctly.
    w_sel_inr   = ({1'b0, w_sel_addr} < (ADDR_W+1)'(DEPTH));
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (w_pick_vld) w_state_nxt = ISSUE;
      ISSUE:   w_state_nxt = r_we ? IDLE : RDATA;
      RDATA:   w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_state <= IDLE;
    else          r_state <= w_state_nxt;
  end

  // Output registers are loaded on the transition into the state they belong to.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_last     <= REQ_LOCAL;
      r_owner    <= REQ_PARSER;
      r_we       <= 1'b0;
      r_inr      <= 1'b0;
      r_p_gnt    <= 1'b0;
      r_l_gnt    <= 1'b0;
      r_p_err    <= 1'b0;
      r_l_err    <= 1'b0;
      r_p_rvalid <= 1'b0;
      r_l_rvalid <= 1'b0;
      r_rf_en    <= 1'b0;
      r_rf_we    <= 1'b0;
      r_rd_sel   <= 1'b0;
      r_rf_addr  <= '0;
      r_rf_wdata <= '0;
    end else begin
      r_p_gnt    <= 1'b0;
      r_l_gnt    <= 1'b0;
      r_p_err    <= 1'b0;
      r_l_err    <= 1'b0;
      r_p_rvalid <= 1'b0;
      r_l_rvalid <= 1'b0;
      r_rf_en    <= 1'b0;
      r_rf_we    <= 1'b0;
      r_rd_sel   <= 1'b0;
      if (r_state == IDLE && w_pick_vld) begin
        r_last     <= w_pick_win;
        r_owner    <= w_pick_win;
        r_we       <= w_sel_we;
        r_inr      <= w_sel_inr;
        r_p_gnt    <= (w_pick_win == REQ_PARSER);
        r_l_gnt    <= (w_pick_win == REQ_LOCAL);
        r_p_err    <= (w_pick_win == REQ_PARSER) && !w_sel_inr;
        r_l_err    <= (w_pick_win == REQ_LOCAL)  && !w_sel_inr;
        r_rf_en    <= w_sel_inr;
        r_rf_we    <= w_sel_inr && w_sel_we;
        r_rf_addr  <= w_sel_addr;
        r_rf_wdata <= w_sel_wdata;
      end
      if (r_state == ISSUE && !r_we) begin
        r_p_rvalid <= (r_owner == REQ_PARSER);
        r_l_rvalid <= (r_owner == REQ_LOCAL);
        r_rd_sel   <= r_inr;
      end
    end
  end

  assign bus.p_gnt    = r_p_gnt;
  assign bus.l_gnt    = r_l_gnt;
  assign bus.p_err    = r_p_err;
  assign bus.l_err    = r_l_err;
  assign bus.p_rvalid = r_p_rvalid;
  assign bus.l_rvalid = r_l_rvalid;
  assign bus.rf_en    = r_rf_en;
  assign bus.rf_we    = r_rf_we;
  assign bus.rf_addr  = r_rf_addr;
  assign bus.rf_wdata = r_rf_wdata;
  assign bus.busy     = (r_state != IDLE);
  // The file's read port is already registered; a registered select gates it.
  assign bus.rd_data  = r_rd_sel ? bus.rf_rdata : '0;
endmodule

// File: tb/tb_regfile_access_arbiter.sv
// Directed bench for regfile_access_arbiter with a behavioural register file.
module tb_regfile_access_arbiter;
  logic clk;
  logic rst_n;
  int   n_assert;
  int   n_fail;

  regfile_arb_if #(.DATA_W(8), .ADDR_W(8)) bus ();

  regfile_access_arbiter #(.DATA_W(8), .ADDR_W(8), .DEPTH(16)) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [7:0] mem [0:255];
  always @(posedge clk) begin
    if (bus.rf_en) begin
      if (bus.rf_we) mem[bus.rf_addr] <= bus.rf_wdata;
      else           bus.rf_rdata     <= mem[bus.rf_addr];
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic p_cmd(input logic we, input logic [7:0] addr, input logic [7:0] wd);
    bus.p_we = we; bus.p_addr = addr; bus.p_wdata = wd; bus.p_req = 1'b1;
  endtask

  task automatic l_cmd(input logic we, input logic [7:0] addr, input logic [7:0] wd);
    bus.l_we = we; bus.l_addr = addr; bus.l_wdata = wd; bus.l_req = 1'b1;
  endtask

  // Parser read: request, grant next cycle, data the cycle after, back to IDLE.
  task automatic p_read(input string tag, input logic [7:0] addr, input logic [7:0] exp);
    p_cmd(1'b0, addr, 8'h00);
    step();
    chk({tag, "_gnt"}, 32'(bus.p_gnt), 32'd1);
    bus.p_req = 1'b0;
    step();
    chk({tag, "_rvalid"}, 32'(bus.p_rvalid), 32'd1);
    chk({tag, "_data"}, 32'(bus.rd_data), 32'(exp));
    step();
  endtask

  initial begin
    n_assert = 0;
    n_fail   = 0;
    rst_n = 1'b0;
    bus.p_req = 0; bus.p_we = 0; bus.p_addr = 0; bus.p_wdata = 0;
    bus.l_req = 0; bus.l_we = 0; bus.l_addr = 0; bus.l_wdata = 0;
    #12;
    chk("rst_busy",  32'(bus.busy), 32'd0);
    chk("rst_gnt",   32'({bus.p_gnt, bus.l_gnt}), 32'd0);
    chk("rst_rf_en", 32'(bus.rf_en), 32'd0);
    chk("rst_addr",  32'(bus.rf_addr), 32'd0);
    chk("rst_rdata", 32'(bus.rd_data), 32'd0);
    @(posedge clk); #1 rst_n = 1'b1;
    step();

    // Tie after reset: parser first, local two cycles later.
    p_cmd(1'b1, 8'h01, 8'h11);
    l_cmd(1'b1, 8'h02, 8'h22);
    step();
    chk("tie_p_gnt", 32'({bus.p_gnt, bus.l_gnt}), 32'b10);
    chk("tie_p_addr", 32'(bus.rf_addr), 32'h01);
    bus.p_req = 1'b0;
    step();
    chk("tie_idle_busy", 32'(bus.busy), 32'd0);
    step();
    chk("tie_l_gnt", 32'({bus.p_gnt, bus.l_gnt}), 32'b01);
    chk("tie_l_wr", 32'({bus.rf_en, bus.rf_we, bus.rf_addr, bus.rf_wdata}), 32'h3_02_22);
    bus.l_req = 1'b0;
    step();
    p_read("rb01", 8'h01, 8'h11);
    p_read("rb02", 8'h02, 8'h22);

    // Parser write 0x05 <- 0xAA then readback.
    p_cmd(1'b1, 8'h05, 8'hAA);
    step();
    chk("w05_gnt", 32'(bus.p_gnt), 32'd1);
    chk("w05_rf", 32'({bus.rf_en, bus.rf_we, bus.rf_addr, bus.rf_wdata}), 32'h3_05_AA);
    chk("w05_busy", 32'(bus.busy), 32'd1);
    bus.p_req = 1'b0;
    step();
    chk("w05_idle", 32'({bus.busy, bus.p_gnt}), 32'd0);
    p_cmd(1'b0, 8'h05, 8'h00);
    step();
    chk("r05_issue", 32'({bus.p_gnt, bus.rf_en, bus.rf_we, bus.rf_addr}), 32'h6_05);
    bus.p_req = 1'b0;
    step();
    chk("r05_rvalid", 32'({bus.p_rvalid, bus.l_rvalid, bus.l_gnt}), 32'b100);
    chk("r05_data", 32'(bus.rd_data), 32'hAA);
    step();
    chk("r05_after", 32'({bus.busy, bus.p_rvalid, bus.rd_data}), 32'd0);

    // Local streams writes; parser cuts in once.
    l_cmd(1'b1, 8'h03, 8'h33);
    step();
    chk("rr_l1", 32'({bus.p_gnt, bus.l_gnt}), 32'b01);
    p_cmd(1'b1, 8'h04, 8'h44);
    step();
    chk("rr_idle", 32'({bus.busy, bus.p_gnt, bus.l_gnt}), 32'd0);
    step();
    chk("rr_p", 32'({bus.p_gnt, bus.l_gnt}), 32'b10);
    chk("rr_p_addr", 32'(bus.rf_addr), 32'h04);
    bus.p_req = 1'b0;
    step();
    step();
    chk("rr_l2", 32'({bus.p_gnt, bus.l_gnt}), 32'b01);
    bus.l_req = 1'b0;
    step();
    p_read("rb04", 8'h04, 8'h44);
    p_read("rb03", 8'h03, 8'h33);

    // Address range boundaries.
    p_cmd(1'b1, 8'h0F, 8'hC3);
    step();
    chk("w0F", 32'({bus.p_gnt, bus.p_err, bus.rf_en, bus.rf_we}), 32'b1011);
    bus.p_req = 1'b0;
    step();
    p_cmd(1'b1, 8'h10, 8'h99);
    step();
    chk("w10_err", 32'({bus.p_gnt, bus.p_err, bus.rf_en, bus.rf_we, bus.l_err}), 32'b11000);
    bus.p_req = 1'b0;
    step();
    p_cmd(1'b1, 8'h85, 8'h99);
    step();
    chk("w85_err", 32'({bus.p_gnt, bus.p_err, bus.rf_en}), 32'b110);
    bus.p_req = 1'b0;
    step();
    p_read("rb0F", 8'h0F, 8'hC3);
    p_cmd(1'b0, 8'h14, 8'h00);
    step();
    chk("r14_issue", 32'({bus.p_gnt, bus.p_err, bus.rf_en}), 32'b110);
    bus.p_req = 1'b0;
    step();
    chk("r14_rvalid", 32'({bus.p_rvalid, bus.p_err}), 32'b10);
    chk("r14_data", 32'(bus.rd_data), 32'h00);
    step();

    // Back-to-back reads 0x05 / 0x06.
    p_cmd(1'b1, 8'h06, 8'h5B);
    step();
    bus.p_req = 1'b0;
    step();
    p_cmd(1'b0, 8'h05, 8'h00);
    step();
    bus.p_req = 1'b0;
    step();
    chk("b2b_rv1", 32'({bus.p_rvalid, bus.busy, bus.rd_data}), 32'h3_AA);
    p_cmd(1'b0, 8'h06, 8'h00);
    step();
    chk("b2b_gap", 32'({bus.busy, bus.p_rvalid}), 32'd0);
    step();
    chk("b2b_issue", 32'({bus.busy, bus.p_gnt}), 32'b11);
    bus.p_req = 1'b0;
    step();
    chk("b2b_rv2", 32'({bus.p_rvalid, bus.busy, bus.rd_data}), 32'h3_5B);
    step();

    // Reset during a local read's RDATA cycle.
    l_cmd(1'b0, 8'h05, 8'h00);
    step();
    chk("rr_lrd_gnt", 32'(bus.l_gnt), 32'd1);
    bus.l_req = 1'b0;
    step();
    #1 rst_n = 1'b0;
    #1;
    chk("mid_rst_out", 32'({bus.l_rvalid, bus.busy, bus.l_gnt, bus.rf_en, bus.rf_we}), 32'd0);
    chk("mid_rst_bus", 32'({bus.rd_data, bus.rf_addr, bus.rf_wdata}), 32'd0);
    step();
    chk("mid_rst_hold", 32'({bus.l_rvalid, bus.busy}), 32'd0);
    #1 rst_n = 1'b1;
    step();
    chk("post_rst_busy", 32'(bus.busy), 32'd0);
    p_cmd(1'b1, 8'h07, 8'h77);
    l_cmd(1'b1, 8'h08, 8'h88);
    step();
    chk("post_rst_tie", 32'({bus.p_gnt, bus.l_gnt}), 32'b10);
    bus.p_req = 1'b0;
    step();
    step();
    chk("post_rst_l", 32'({bus.p_gnt, bus.l_gnt}), 32'b01);
    bus.l_req = 1'b0;
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
